// File: rtl/fhe_cpu.sv
// rtl/fhe_cpu.sv - RNS BFV ciphertext arithmetic coprocessor; optional busy_out port under FHE_CPU_BUSY_EN

package fhe_types_pkg;
    localparam int RNS_PRIME_BITS = 16;
    localparam int N_SLOTS        = 4;
    localparam int N_PRIMES       = 2;
    localparam int IDX_W          = 4;

    typedef logic [RNS_PRIME_BITS-1:0] rns_residue_t;
    typedef rns_residue_t [N_SLOTS-1:0][N_PRIMES-1:0] q_BASIS_poly;

    localparam rns_residue_t q_BASIS [N_PRIMES] = '{16'd65521, 16'd65497};

    typedef enum logic [2:0] {
        NO_OP,
        OP_CT_CT_ADD,
        OP_CT_PT_ADD,
        OP_CT_PT_MUL,
        OP_CT_CT_MUL
    } op_mode_t;

    typedef struct packed {
        op_mode_t         mode;
        logic [IDX_W-1:0] idx1_a;
        logic [IDX_W-1:0] idx1_b;
        logic [IDX_W-1:0] idx2_a;
        logic [IDX_W-1:0] idx2_b;
        logic [IDX_W-1:0] out_a;
        logic [IDX_W-1:0] out_b;
    } operation;

    // a+b kept one bit wider so the single conditional subtract is exact
    function automatic rns_residue_t mod_add(rns_residue_t a, rns_residue_t b, rns_residue_t q);
        logic [RNS_PRIME_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[RNS_PRIME_BITS-1:0];
    endfunction

    function automatic rns_residue_t mod_reduce(logic [2*RNS_PRIME_BITS-1:0] p, rns_residue_t q);
        logic [2*RNS_PRIME_BITS-1:0] r;
        r = p % {{RNS_PRIME_BITS{1'b0}}, q};
        return r[RNS_PRIME_BITS-1:0];
    endfunction
endpackage

module fhe_rf
    import fhe_types_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr_a,
    input  q_BASIS_poly   wdata_a,
    input  logic [AW-1:0] waddr_b,
    input  q_BASIS_poly   wdata_b,
    input  logic [AW-1:0] raddr [4],
    output q_BASIS_poly   rdata [4]
);
    q_BASIS_poly mem [NUM_REGS];

    // both halves land on one edge; port b is written last so it wins on aliasing
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr_a] <= wdata_a;
            mem[waddr_b] <= wdata_b;
        end
    end

    // asynchronous reads so all four sources are snapshotted at the capture edge
    always_comb begin
        for (int i = 0; i < 4; i++)
            rdata[i] = mem[raddr[i]];
    end
endmodule

module fhe_cpu
    import fhe_types_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int MUL_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  operation op,
`ifdef FHE_CPU_BUSY_EN
    output logic     busy_out,
`endif
    output logic     done_out
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int PW    = 2 * RNS_PRIME_BITS;
    localparam int CNT_W = $clog2(MUL_STAGES + 1) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB, DONE} state_t;

    state_t           state, state_nxt;
    op_mode_t         cmd_mode;
    logic [AW-1:0]    cmd_out_a, cmd_out_b;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             wr_en;

    q_BASIS_poly      op1a, op1b, op2a, op2b;
    logic [AW-1:0]    raddr [4];
    q_BASIS_poly      rdata [4];
    q_BASIS_poly      res_a, res_b;
    q_BASIS_poly      red_a, red_x, red_b, sum_a;

    logic [PW-1:0]    pipe_a [MUL_STAGES][N_SLOTS][N_PRIMES];
    logic [PW-1:0]    pipe_x [MUL_STAGES][N_SLOTS][N_PRIMES];
    logic [PW-1:0]    pipe_b [MUL_STAGES][N_SLOTS][N_PRIMES];
    logic [MUL_STAGES-1:0] mul_vld;
    logic             add_vld;

    assign capture  = (state == IDLE) && (op.mode != NO_OP);
    assign raddr[0] = op.idx1_a[AW-1:0];
    assign raddr[1] = op.idx1_b[AW-1:0];
    assign raddr[2] = op.idx2_a[AW-1:0];
    assign raddr[3] = op.idx2_b[AW-1:0];

    fhe_rf #(.NUM_REGS(NUM_REGS)) u_rf_q (
        .clk     (clk),
        .we      (wr_en),
        .waddr_a (cmd_out_a),
        .wdata_a (res_a),
        .waddr_b (cmd_out_b),
        .wdata_b (res_b),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    // control state: FSM, latched command fields and the EXEC countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_mode  <= NO_OP;
            cmd_out_a <= '0;
            cmd_out_b <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cmd_mode  <= op.mode;
                cmd_out_a <= op.out_a[AW-1:0];
                cmd_out_b <= op.out_b[AW-1:0];
                // CT_CT_MUL spends one extra EXEC cycle for its add stage
                cnt       <= (op.mode == OP_CT_CT_MUL) ? CNT_W'(MUL_STAGES) : CNT_W'(MUL_STAGES - 1);
            end else if (state == EXEC) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // next-state and status outputs
    always_comb begin
        state_nxt = state;
        done_out  = 1'b0;
        case (state)
            IDLE: if (capture)
                      state_nxt = (op.mode == OP_CT_CT_ADD || op.mode == OP_CT_PT_ADD) ? WB : EXEC;
            EXEC: if (cnt == '0) state_nxt = WB;
            WB:   state_nxt = DONE;
            DONE: begin
                      done_out  = 1'b1;
                      state_nxt = IDLE;
                  end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FHE_CPU_BUSY_EN
    assign busy_out = (state != IDLE);
`endif

    // source snapshot; operands stay frozen for the whole command
    always_ff @(posedge clk) begin
        if (capture) begin
            op1a <= rdata[0];
            op1b <= rdata[1];
            op2a <= rdata[2];
            op2b <= rdata[3];
        end
    end

    // pipeline valids only mark data in flight; reset aborts them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_vld <= '0;
            add_vld <= 1'b0;
        end else begin
            mul_vld[0] <= (state == EXEC);
            for (int k = 1; k < MUL_STAGES; k++)
                mul_vld[k] <= mul_vld[k-1];
            add_vld <= mul_vld[MUL_STAGES-1];
        end
    end

    // three product lanes: A1*op2b, A2*B1, B1*op2b (op2b is either PT or B2)
    always_ff @(posedge clk) begin
        for (int s = 0; s < N_SLOTS; s++) begin
            for (int p = 0; p < N_PRIMES; p++) begin
                pipe_a[0][s][p] <= PW'(op1a[s][p]) * PW'(op2b[s][p]);
                pipe_x[0][s][p] <= PW'(op2a[s][p]) * PW'(op1b[s][p]);
                pipe_b[0][s][p] <= PW'(op1b[s][p]) * PW'(op2b[s][p]);
                for (int k = 1; k < MUL_STAGES; k++) begin
                    pipe_a[k][s][p] <= pipe_a[k-1][s][p];
                    pipe_x[k][s][p] <= pipe_x[k-1][s][p];
                    pipe_b[k][s][p] <= pipe_b[k-1][s][p];
                end
                sum_a[s][p] <= mod_add(red_a[s][p], red_x[s][p], q_BASIS[p]);
            end
        end
    end

    // modular reduction at the multiplier pipeline output
    always_comb begin
        red_a = '0;
        red_x = '0;
        red_b = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            for (int p = 0; p < N_PRIMES; p++) begin
                red_a[s][p] = mod_reduce(pipe_a[MUL_STAGES-1][s][p], q_BASIS[p]);
                red_x[s][p] = mod_reduce(pipe_x[MUL_STAGES-1][s][p], q_BASIS[p]);
                red_b[s][p] = mod_reduce(pipe_b[MUL_STAGES-1][s][p], q_BASIS[p]);
            end
        end
    end

    // result select per mode and write-back enable
    always_comb begin
        res_a = op1a;
        res_b = op1b;
        wr_en = 1'b0;
        case (cmd_mode)
            OP_CT_CT_ADD: begin
                for (int s = 0; s < N_SLOTS; s++)
                    for (int p = 0; p < N_PRIMES; p++) begin
                        res_a[s][p] = mod_add(op1a[s][p], op2a[s][p], q_BASIS[p]);
                        res_b[s][p] = mod_add(op1b[s][p], op2b[s][p], q_BASIS[p]);
                    end
                wr_en = (state == WB);
            end
            OP_CT_PT_ADD: begin
                for (int s = 0; s < N_SLOTS; s++)
                    for (int p = 0; p < N_PRIMES; p++)
                        res_b[s][p] = mod_add(op1b[s][p], op2b[s][p], q_BASIS[p]);
                wr_en = (state == WB);
            end
            OP_CT_PT_MUL: begin
                res_a = red_a;
                res_b = red_b;
                wr_en = (state == WB) && mul_vld[MUL_STAGES-1];
            end
            OP_CT_CT_MUL: begin
                res_a = sum_a;
                res_b = red_b;
                wr_en = (state == WB) && add_vld;
            end
            default: wr_en = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_fhe_cpu.sv
// tb/tb_fhe_cpu.sv - self-checking bench for fhe_cpu against an integer reference model
module tb_fhe_cpu;
    import fhe_types_pkg::*;

    localparam int MS = 2;
    localparam int NR = 16;

    logic     clk = 1'b0;
    logic     reset;
    operation op;
    logic     done_out;
`ifdef FHE_CPU_BUSY_EN
    logic     busy_out;
`endif

    int errors = 0;
    int checks = 0;
    longint model [NR][N_SLOTS][N_PRIMES];

    always #5 clk = ~clk;

    fhe_cpu #(.NUM_REGS(NR), .MUL_STAGES(MS)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
`ifdef FHE_CPU_BUSY_EN
        .busy_out (busy_out),
`endif
        .done_out (done_out)
    );

    task automatic set_res(int r, int s, int p, longint v);
        model[r][s][p] = v;
        dut.u_rf_q.mem[r][s][p] = rns_residue_t'(v);
    endtask

    task automatic fill(int r, longint v);
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                set_res(r, s, p, v);
    endtask

    task automatic fill_rel(int r, longint off);
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                set_res(r, s, p, longint'(q_BASIS[p]) - off);
    endtask

    task automatic fill_rand(int r);
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                set_res(r, s, p, longint'($urandom_range(int'(q_BASIS[p]) - 1, 0)));
    endtask

    function automatic q_BASIS_poly model_poly(int r);
        q_BASIS_poly pp;
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                pp[s][p] = rns_residue_t'(model[r][s][p]);
        return pp;
    endfunction

    function automatic q_BASIS_poly const_poly(longint v);
        q_BASIS_poly pp;
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                pp[s][p] = rns_residue_t'(v);
        return pp;
    endfunction

    // reference semantics in plain integer arithmetic; sources read before any write
    function automatic void model_apply(op_mode_t m, int i1a, int i1b, int i2a, int i2b, int oa, int ob);
        longint na [N_SLOTS][N_PRIMES];
        longint nb [N_SLOTS][N_PRIMES];
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++) begin
                longint q, a1, b1, a2, b2;
                q  = longint'(q_BASIS[p]);
                a1 = model[i1a][s][p];
                b1 = model[i1b][s][p];
                a2 = model[i2a][s][p];
                b2 = model[i2b][s][p];
                case (m)
                    OP_CT_CT_ADD: begin na[s][p] = (a1 + a2) % q; nb[s][p] = (b1 + b2) % q; end
                    OP_CT_PT_ADD: begin na[s][p] = a1;            nb[s][p] = (b1 + b2) % q; end
                    OP_CT_PT_MUL: begin na[s][p] = (a1 * b2) % q; nb[s][p] = (b1 * b2) % q; end
                    default:      begin na[s][p] = (a1 * b2 + a2 * b1) % q; nb[s][p] = (b1 * b2) % q; end
                endcase
            end
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                model[oa][s][p] = na[s][p];
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                model[ob][s][p] = nb[s][p];
    endfunction

    function automatic int exp_lat(op_mode_t m);
        if (m == OP_CT_PT_MUL) return MS + 2;
        if (m == OP_CT_CT_MUL) return MS + 3;
        return 2;
    endfunction

    task automatic set_op(op_mode_t m, int i1a, int i1b, int i2a, int i2b, int oa, int ob);
        op.mode   = m;
        op.idx1_a = IDX_W'(i1a);
        op.idx1_b = IDX_W'(i1b);
        op.idx2_a = IDX_W'(i2a);
        op.idx2_b = IDX_W'(i2b);
        op.out_a  = IDX_W'(oa);
        op.out_b  = IDX_W'(ob);
    endtask

    // drives one command; lat counts falling edges after capture until done_out (-1 on timeout)
    task automatic issue(op_mode_t m, int i1a, int i1b, int i2a, int i2b, int oa, int ob,
                         output int lat, output logic pre_done, output logic post_done);
        int n;
        @(negedge clk);
        set_op(m, i1a, i1b, i2a, i2b, oa, ob);
        pre_done = done_out;
        @(negedge clk);
        op.mode = NO_OP;
        n = 1;
        while (done_out !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = (done_out === 1'b1) ? n : -1;
        @(negedge clk);
        post_done = done_out;
    endtask

    task automatic test_reset();
        int pulses = 0;
        reset = 1'b1;
        set_op(NO_OP, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (done_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", done_out);
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_out === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL idle_quiet got=%0d pulses exp=0", pulses);
        end
    endtask

    task automatic test_ct_ct_add();
        int lat;
        logic pre, post;
        fill(0, 5); fill(1, 10); fill(2, 7); fill(3, 3); fill(4, 4);
        issue(OP_CT_CT_ADD, 0, 1, 2, 3, 5, 6, lat, pre, post);
        model_apply(OP_CT_CT_ADD, 0, 1, 2, 3, 5, 6);
        checks++;
        if (lat !== 2 || pre !== 1'b0 || post !== 1'b0) begin
            errors++;
            $display("FAIL ctct_add_timing got lat=%0d pre=%b post=%b exp lat=2 pre=0 post=0", lat, pre, post);
        end
        checks++;
        if (dut.u_rf_q.mem[5] !== const_poly(12)) begin
            errors++;
            $display("FAIL ctct_add_a got=%h exp=%h", dut.u_rf_q.mem[5], const_poly(12));
        end
        checks++;
        if (dut.u_rf_q.mem[6] !== const_poly(13)) begin
            errors++;
            $display("FAIL ctct_add_b got=%h exp=%h", dut.u_rf_q.mem[6], const_poly(13));
        end
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (dut.u_rf_q.mem[r] !== model_poly(r)) begin
                errors++;
                $display("FAIL ctct_add_src%0d got=%h exp=%h", r, dut.u_rf_q.mem[r], model_poly(r));
            end
        end
    endtask

    task automatic test_ct_pt_add();
        int lat;
        logic pre, post;
        fill_rand(0);
        fill_rel(1, 2);
        fill(4, 5);
        issue(OP_CT_PT_ADD, 0, 1, 2, 4, 7, 8, lat, pre, post);
        model_apply(OP_CT_PT_ADD, 0, 1, 2, 4, 7, 8);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL ctpt_add_lat got=%0d exp=2", lat);
        end
        checks++;
        if (dut.u_rf_q.mem[7] !== model_poly(0)) begin
            errors++;
            $display("FAIL ctpt_add_a got=%h exp=%h", dut.u_rf_q.mem[7], model_poly(0));
        end
        checks++;
        if (dut.u_rf_q.mem[8] !== const_poly(3)) begin
            errors++;
            $display("FAIL ctpt_add_wrap got=%h exp=%h", dut.u_rf_q.mem[8], const_poly(3));
        end
    endtask

    task automatic test_ct_pt_mul();
        int lat;
        logic pre, post;
        fill(0, 5); fill(1, 10); fill(4, 4);
        issue(OP_CT_PT_MUL, 0, 1, 3, 4, 9, 10, lat, pre, post);
        model_apply(OP_CT_PT_MUL, 0, 1, 3, 4, 9, 10);
        checks++;
        if (lat !== MS + 2 || pre !== 1'b0 || post !== 1'b0) begin
            errors++;
            $display("FAIL ctpt_mul_timing got lat=%0d pre=%b post=%b exp lat=%0d", lat, pre, post, MS + 2);
        end
        checks++;
        if (dut.u_rf_q.mem[9] !== const_poly(20) || dut.u_rf_q.mem[10] !== const_poly(40)) begin
            errors++;
            $display("FAIL ctpt_mul_small got=%h,%h exp=%h,%h", dut.u_rf_q.mem[9], dut.u_rf_q.mem[10],
                     const_poly(20), const_poly(40));
        end
        fill_rel(0, 1);
        fill_rel(4, 1);
        issue(OP_CT_PT_MUL, 0, 1, 3, 4, 9, 10, lat, pre, post);
        model_apply(OP_CT_PT_MUL, 0, 1, 3, 4, 9, 10);
        checks++;
        if (dut.u_rf_q.mem[9] !== const_poly(1)) begin
            errors++;
            $display("FAIL ctpt_mul_qm1 got=%h exp=%h", dut.u_rf_q.mem[9], const_poly(1));
        end
        checks++;
        if (dut.u_rf_q.mem[10] !== model_poly(10)) begin
            errors++;
            $display("FAIL ctpt_mul_b got=%h exp=%h", dut.u_rf_q.mem[10], model_poly(10));
        end
    endtask

    task automatic test_ct_ct_mul();
        int lat;
        logic pre, post;
        fill(0, 5); fill(1, 10); fill(2, 7); fill(3, 3);
        issue(OP_CT_CT_MUL, 0, 1, 2, 3, 9, 10, lat, pre, post);
        model_apply(OP_CT_CT_MUL, 0, 1, 2, 3, 9, 10);
        checks++;
        if (lat < 1 || lat > MS + 3 || post !== 1'b0) begin
            errors++;
            $display("FAIL ctct_mul_lat got=%0d post=%b exp<=%0d", lat, post, MS + 3);
        end
        checks++;
        if (dut.u_rf_q.mem[9] !== const_poly(85)) begin
            errors++;
            $display("FAIL ctct_mul_a got=%h exp=%h", dut.u_rf_q.mem[9], const_poly(85));
        end
        checks++;
        if (dut.u_rf_q.mem[10] !== const_poly(30)) begin
            errors++;
            $display("FAIL ctct_mul_b got=%h exp=%h", dut.u_rf_q.mem[10], const_poly(30));
        end
    endtask

    task automatic test_hold();
        int pulses = 0;
        for (int r = 0; r < 4; r++) fill_rand(r);
        @(negedge clk);
        set_op(OP_CT_CT_ADD, 0, 1, 2, 3, 0, 1);
        repeat (3) begin
            @(negedge clk);
            if (done_out === 1'b1) pulses++;
        end
        op.mode = NO_OP;
        repeat (6) begin
            @(negedge clk);
            if (done_out === 1'b1) pulses++;
        end
        model_apply(OP_CT_CT_ADD, 0, 1, 2, 3, 0, 1);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL hold_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (dut.u_rf_q.mem[0] !== model_poly(0) || dut.u_rf_q.mem[1] !== model_poly(1)) begin
            errors++;
            $display("FAIL hold_once got=%h,%h exp=%h,%h", dut.u_rf_q.mem[0], dut.u_rf_q.mem[1],
                     model_poly(0), model_poly(1));
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        int lat;
        logic pre, post;
        for (int r = 0; r < 12; r++) fill_rand(r);
        @(negedge clk);
        set_op(OP_CT_CT_MUL, 0, 1, 2, 3, 9, 10);
        @(negedge clk);
        op.mode = NO_OP;
        reset   = 1'b1;
        @(negedge clk);
        if (done_out === 1'b1) pulses++;
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_out === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_done got=%0d pulses done=%b exp=0", pulses, done_out);
        end
        checks++;
        if (dut.u_rf_q.mem[9] !== model_poly(9) || dut.u_rf_q.mem[10] !== model_poly(10)) begin
            errors++;
            $display("FAIL abort_mem got=%h,%h exp=%h,%h", dut.u_rf_q.mem[9], dut.u_rf_q.mem[10],
                     model_poly(9), model_poly(10));
        end
        issue(OP_CT_CT_ADD, 4, 5, 6, 7, 11, 11, lat, pre, post);
        model_apply(OP_CT_CT_ADD, 4, 5, 6, 7, 11, 11);
        checks++;
        if (lat !== 2 || dut.u_rf_q.mem[11] !== model_poly(11)) begin
            errors++;
            $display("FAIL abort_recover got lat=%0d mem=%h exp lat=2 mem=%h", lat, dut.u_rf_q.mem[11], model_poly(11));
        end
    endtask

    task automatic test_random();
        int lat;
        logic pre, post;
        op_mode_t m;
        int ix [6];
        for (int r = 0; r < NR; r++) fill_rand(r);
        for (int it = 0; it < 12; it++) begin
            m = op_mode_t'($urandom_range(4, 1));
            for (int k = 0; k < 6; k++) ix[k] = int'($urandom_range(NR - 1, 0));
            issue(m, ix[0], ix[1], ix[2], ix[3], ix[4], ix[5], lat, pre, post);
            model_apply(m, ix[0], ix[1], ix[2], ix[3], ix[4], ix[5]);
            checks++;
            if (lat !== exp_lat(m) || pre !== 1'b0 || post !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_timing mode=%0d got lat=%0d pre=%b post=%b exp lat=%0d",
                         it, m, lat, pre, post, exp_lat(m));
            end
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (dut.u_rf_q.mem[r] !== model_poly(r)) begin
                    errors++;
                    $display("FAIL rand%0d_mem%0d mode=%0d got=%h exp=%h", it, r, m, dut.u_rf_q.mem[r], model_poly(r));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_op(NO_OP, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_ct_ct_add();
        test_ct_pt_add();
        test_ct_pt_mul();
        test_ct_ct_mul();
        test_hold();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
